vrf_wb_sequencer: RTL



---
 rtl/vc_pkg.sv | 24 ++
 rtl/vc_wb_fifo.sv | 78 +++++++
 rtl/vrf_wb_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the vector-register writeback path.
// - wb_state_t : writeback sequencer FSM states.
// - addr_b()   : address width for a register file of a given depth.
// - elem_b()   : element-index width for a given number of lanes.
// The helpers clamp to a minimum of one bit so degenerate sizes still give
// legal vector widths.
package vc_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_REQ   = 2'd1,
    WB_WRITE = 2'd2,
    WB_WAIT  = 2'd3
  } wb_state_t;

  function automatic int addr_b(input int reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

  function automatic int elem_b(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vc_wb_fifo.sv
// Two-entry result buffer for the writeback sequencer.
// Ports:
//   clk_i, resetn_i           clock, async active-low reset
//   push_i, push_*_i          write one {addr, data, en} entry at the tail
//   pop_i                     drop the head entry
//   count_o                   number of buffered entries (0..2)
//   head_*_o                  head entry fields
//   slot_valid_o/slot_addr_o  per-slot occupancy and destination, used for
//                             read-after-write hazard detection
// The caller guarantees no push when full and no pop when empty.
module vc_wb_fifo #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int LANES = 4
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_addr_i,
  input  logic [LANES*DW-1:0]    push_data_i,
  input  logic [LANES-1:0]       push_en_i,
  input  logic                   pop_i,
  output logic [1:0]             count_o,
  output logic [AW-1:0]          head_addr_o,
  output logic [LANES*DW-1:0]    head_data_o,
  output logic [LANES-1:0]       head_en_o,
  output logic [1:0]             slot_valid_o,
  output logic [1:0][AW-1:0]     slot_addr_o
);

  logic [AW-1:0]       addr_q [2];
  logic [LANES*DW-1:0] data_q [2];
  logic [LANES-1:0]    en_q   [2];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [1:0]          count_q;

  // NOTE: payload storage has no reset; an entry is only meaningful while
  // count/pointers mark it occupied, so clearing it would buy nothing.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
      en_q[wr_ptr_q]   <= push_en_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    count_o         = count_q;
    head_addr_o     = addr_q[rd_ptr_q];
    head_data_o     = data_q[rd_ptr_q];
    head_en_o       = en_q[rd_ptr_q];
    // With one entry only the slot under the read pointer is live.
    slot_valid_o[0] = (count_q == 2'd2) || ((count_q == 2'd1) && !rd_ptr_q);
    slot_valid_o[1] = (count_q == 2'd2) || ((count_q == 2'd1) &&  rd_ptr_q);
    slot_addr_o[0]  = addr_q[0];
    slot_addr_o[1]  = addr_q[1];
  end

endmodule

// File: rtl/vrf_wb_sequencer.sv
// Writeback sequencer in front of one VRF lane.
// Buffers up to two whole-register results and serializes each into the VRF
// write port one element per cycle: a wr_req_o cycle, LANES element cycles,
// then a wait for wr_ready_i which retires the entry.
// Ports:
//   clk_i, resetn_i                       clock, async active-low reset
//   res_valid_i/res_ready_o               result handshake
//   res_addr_i/res_data_i/res_en_i        destination, packed elements, enables
//   wr_req_o/wr_en_o/wr_addr_o            VRF write request/strobe/address
//   wr_elem_cnt_o/wdata_o                 element index and data
//   wr_ready_i                            VRF accepts completion of the write
//   chk_addr_i/hazard_o                   RAW check against buffered entries
//   busy_o                                work buffered or in flight
//   done_o                                one-cycle pulse per retired register
module vrf_wb_sequencer
  import vc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic [addr_b(REG_NUM)-1:0]    res_addr_i,
  input  logic [LANES*DATA_WIDTH-1:0]   res_data_i,
  input  logic [LANES-1:0]              res_en_i,
  output logic                          wr_req_o,
  output logic                          wr_en_o,
  output logic [addr_b(REG_NUM)-1:0]    wr_addr_o,
  output logic [elem_b(LANES)-1:0]      wr_elem_cnt_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  input  logic                          wr_ready_i,
  input  logic [addr_b(REG_NUM)-1:0]    chk_addr_i,
  output logic                          hazard_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int ADDR_B = addr_b(REG_NUM);
  localparam int ELEM_B = elem_b(LANES);
  localparam logic [ELEM_B-1:0] LAST_ELEM = ELEM_B'(LANES - 1);

  wb_state_t                  state_q, state_d;
  logic [ELEM_B-1:0]          elem_q, elem_d;
  logic                       push;
  logic                       pop;
  logic [1:0]                 count;
  logic [ADDR_B-1:0]          head_addr;
  logic [LANES*DATA_WIDTH-1:0] head_data;
  logic [LANES-1:0]           head_en;
  logic [1:0]                 slot_valid;
  logic [1:0][ADDR_B-1:0]     slot_addr;

  vc_wb_fifo #(
    .AW   (ADDR_B),
    .DW   (DATA_WIDTH),
    .LANES(LANES)
  ) u_fifo (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .push_i      (push),
    .push_addr_i (res_addr_i),
    .push_data_i (res_data_i),
    .push_en_i   (res_en_i),
    .pop_i       (pop),
    .count_o     (count),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .head_en_o   (head_en),
    .slot_valid_o(slot_valid),
    .slot_addr_o (slot_addr)
  );

  // Ready comes from the registered count only, never from the pop, so the
  // upstream handshake has no combinational path through wr_ready_i.
  assign res_ready_o = (count != 2'd2);
  assign push        = res_valid_i && res_ready_o;
  assign busy_o      = (count != 2'd0) || (state_q != WB_IDLE);
  assign hazard_o    = (slot_valid[0] && (slot_addr[0] == chk_addr_i)) ||
                       (slot_valid[1] && (slot_addr[1] == chk_addr_i));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= WB_IDLE;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    pop           = 1'b0;
    done_o        = 1'b0;
    wr_req_o      = 1'b0;
    wr_en_o       = 1'b0;
    wr_elem_cnt_o = '0;
    wdata_o       = '0;
    wr_addr_o     = (state_q == WB_IDLE) ? '0 : head_addr;

    unique case (state_q)
      WB_IDLE: begin
        if (count != 2'd0) state_d = WB_REQ;
      end
      WB_REQ: begin
        wr_req_o = 1'b1;
        elem_d   = '0;
        state_d  = WB_WRITE;
      end
      WB_WRITE: begin
        wr_elem_cnt_o = elem_q;
        wdata_o       = head_data[int'(elem_q)*DATA_WIDTH +: DATA_WIDTH];
        // Disabled elements still take their slot; only the strobe is masked.
        wr_en_o       = head_en[elem_q];
        if (elem_q == LAST_ELEM) begin
          state_d = WB_WAIT;
        end else begin
          elem_d = elem_q + ELEM_B'(1);
        end
      end
      WB_WAIT: begin
        wr_elem_cnt_o = elem_q;
        if (wr_ready_i) begin
          pop    = 1'b1;
          done_o = 1'b1;
          // A push landing in the pop cycle counts as a remaining entry, so
          // back-to-back registers go straight to the next request.
          state_d = ((count == 2'd2) || push) ? WB_REQ : WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

endmodule
